// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// A synchronous flush or disable inserts a zeroed bubble; a saturating counter tracks downstream stalls.
module pipe_stage_skid #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t              state_p1, state_nxt;
  logic                main_vld_p1, skid_vld_p1;
  logic [CTRL_W-1:0]   main_ctrl_p1, main_ctrl_nxt;
  logic [DATA_W-1:0]   main_data_p1, main_data_nxt;
  logic [CTRL_W-1:0]   skid_ctrl_p1, skid_ctrl_nxt;
  logic [DATA_W-1:0]   skid_data_p1, skid_data_nxt;
  logic [CNT_W-1:0]    stall_cnt_p1;
  logic                acc, rel;

  // in_ready depends only on flops and start_i, never on out_ready_i
  assign in_ready_o = start_i & ~skid_vld_p1;
  assign acc        = in_valid_i & in_ready_o;
  assign rel        = main_vld_p1 & out_ready_i;

  always_comb begin
    state_nxt     = state_p1;
    main_ctrl_nxt = main_ctrl_p1;
    main_data_nxt = main_data_p1;
    skid_ctrl_nxt = skid_ctrl_p1;
    skid_data_nxt = skid_data_p1;
    if (!start_i || flush_i) begin
      state_nxt     = EMPTY;
      main_ctrl_nxt = '0;
      main_data_nxt = '0;
      skid_ctrl_nxt = '0;
      skid_data_nxt = '0;
    end else begin
      unique case (state_p1)
        EMPTY: begin
          if (acc) begin
            state_nxt     = FULL;
            main_ctrl_nxt = in_ctrl_i;
            main_data_nxt = in_data_i;
          end
        end
        FULL: begin
          if (acc && rel) begin
            main_ctrl_nxt = in_ctrl_i;
            main_data_nxt = in_data_i;
          end else if (acc) begin
            state_nxt     = SKID;
            skid_ctrl_nxt = in_ctrl_i;
            skid_data_nxt = in_data_i;
          end else if (rel) begin
            state_nxt     = EMPTY;
            main_ctrl_nxt = '0;
            main_data_nxt = '0;
          end
        end
        SKID: begin
          if (rel) begin
            state_nxt     = FULL;
            main_ctrl_nxt = skid_ctrl_p1;
            main_data_nxt = skid_data_p1;
            skid_ctrl_nxt = '0;
            skid_data_nxt = '0;
          end
        end
        default: begin
          state_nxt     = EMPTY;
          main_ctrl_nxt = '0;
          main_data_nxt = '0;
          skid_ctrl_nxt = '0;
          skid_data_nxt = '0;
        end
      endcase
    end
  end

  // stage boundary: main and skid registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_p1     <= EMPTY;
      main_vld_p1  <= 1'b0;
      skid_vld_p1  <= 1'b0;
      main_ctrl_p1 <= '0;
      main_data_p1 <= '0;
      skid_ctrl_p1 <= '0;
      skid_data_p1 <= '0;
    end else begin
      state_p1     <= state_nxt;
      main_vld_p1  <= (state_nxt != EMPTY);
      skid_vld_p1  <= (state_nxt == SKID);
      main_ctrl_p1 <= main_ctrl_nxt;
      main_data_p1 <= main_data_nxt;
      skid_ctrl_p1 <= skid_ctrl_nxt;
      skid_data_p1 <= skid_data_nxt;
    end
  end

  // stall counter survives flush and disable; only reset clears it
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_p1 <= '0;
    end else if (main_vld_p1 && !out_ready_i) begin
      stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  assign out_valid_o = main_vld_p1;
  assign out_ctrl_o  = main_ctrl_p1;
  assign out_data_o  = main_data_p1;
  assign stall_cnt_o = stall_cnt_p1;

endmodule
